// File: rtl/timer0_pkg.sv
// Shared constants for the timer0 prescaler: clock-select encoding and default divide ratios.
package timer0_pkg;

  localparam logic [2:0] CS_STOP     = 3'b000;
  localparam logic [2:0] CS_DIV1     = 3'b001;
  localparam logic [2:0] CS_DIVA     = 3'b010;
  localparam logic [2:0] CS_DIVB     = 3'b011;
  localparam logic [2:0] CS_DIVC     = 3'b100;
  localparam logic [2:0] CS_DIVD     = 3'b101;
  localparam logic [2:0] CS_EXT_FALL = 3'b110;
  localparam logic [2:0] CS_EXT_RISE = 3'b111;

  localparam int unsigned DEF_CNT_W       = 10;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DIV1        = 8;
  localparam int unsigned DEF_DIV2        = 64;
  localparam int unsigned DEF_DIV3        = 256;
  localparam int unsigned DEF_DIV4        = 1024;

  // Number of low counter bits that a power-of-two divide ratio occupies.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/timer0_prescaler_if.sv
// Control and output bundle between the timer0 core and its prescaler.
interface timer0_prescaler_if;

  logic [2:0] cs;
  logic       psr;
  logic       t0_pin;
  logic       tick;
  logic       div_out;
  logic       active;

  modport master (
    output cs,
    output psr,
    output t0_pin,
    input  tick,
    input  div_out,
    input  active
  );

  modport slave (
    input  cs,
    input  psr,
    input  t0_pin,
    output tick,
    output div_out,
    output active
  );

endinterface

// File: rtl/t0_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus one history flop for edge detection.
module t0_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sync_out = sync_q[SYNC_STAGES-1];
    rise     = sync_out & ~hist_q;
    fall     = ~sync_out & hist_q;
  end

endmodule

// File: rtl/timer0_prescaler.sv
// Fully synchronous timer0 prescaler: one free-running counter producing a one-cycle tick enable,
// a debug square wave, and external-pin clocking on a selectable edge.
module timer0_prescaler
  import timer0_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DIV1        = DEF_DIV1,
  parameter int unsigned DIV2        = DEF_DIV2,
  parameter int unsigned DIV3        = DEF_DIV3,
  parameter int unsigned DIV4        = DEF_DIV4
) (
  input  logic                clk,
  input  logic                rst_n,
  timer0_prescaler_if.slave   bus
);

  localparam logic [CNT_W-1:0] Div1Mask = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] Div2Mask = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] Div3Mask = CNT_W'(DIV3 - 1);
  localparam logic [CNT_W-1:0] Div4Mask = CNT_W'(DIV4 - 1);
  localparam int unsigned Div1Msb = clog2(DIV1) - 1;
  localparam int unsigned Div2Msb = clog2(DIV2) - 1;
  localparam int unsigned Div3Msb = clog2(DIV3) - 1;
  localparam int unsigned Div4Msb = clog2(DIV4) - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             div_q, div_d;
  logic             active_q, active_d;
  logic             tick_cand;
  logic             pin_sync, pin_rise, pin_fall;

  t0_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.t0_pin),
    .sync_out (pin_sync),
    .rise     (pin_rise),
    .fall     (pin_fall)
  );

  always_comb begin
    cnt_d     = bus.psr ? '0 : cnt_q + 1'b1;
    tick_cand = 1'b0;
    div_d     = 1'b0;
    case (bus.cs)
      CS_DIV1: tick_cand = ~bus.psr;
      CS_DIVA: begin
        tick_cand = ((cnt_q & Div1Mask) == Div1Mask) & ~bus.psr;
        div_d     = cnt_d[Div1Msb];
      end
      CS_DIVB: begin
        tick_cand = ((cnt_q & Div2Mask) == Div2Mask) & ~bus.psr;
        div_d     = cnt_d[Div2Msb];
      end
      CS_DIVC: begin
        tick_cand = ((cnt_q & Div3Mask) == Div3Mask) & ~bus.psr;
        div_d     = cnt_d[Div3Msb];
      end
      CS_DIVD: begin
        tick_cand = ((cnt_q & Div4Mask) == Div4Mask) & ~bus.psr;
        div_d     = cnt_d[Div4Msb];
      end
      CS_EXT_FALL: begin
        tick_cand = pin_fall;
        div_d     = pin_sync;
      end
      CS_EXT_RISE: begin
        tick_cand = pin_rise;
        div_d     = pin_sync;
      end
      default: begin
        tick_cand = 1'b0;
        div_d     = 1'b0;
      end
    endcase
    // A mode switch could line up two ticks back to back; only /1 may do that.
    tick_d   = tick_cand & ~(tick_q & (bus.cs != CS_DIV1));
    active_d = (bus.cs != CS_STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      div_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      div_q    <= div_d;
      active_q <= active_d;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.div_out = div_q;
  assign bus.active  = active_q;

endmodule

// File: tb/tb_timer0_prescaler.sv
// Self-checking bench for timer0_prescaler: per-edge scoreboard plus directed timing checks.
module tb_timer0_prescaler;

  localparam int CntW = 10;

  typedef struct packed {
    logic tick;
    logic div;
    logic act;
  } exp_t;

  logic clk;
  logic rst_n;
  timer0_prescaler_if bus ();

  timer0_prescaler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  // Reference state, written from the behavioural description.
  int         m_cnt;
  logic [1:0] m_s;
  logic       m_hist, m_tick, m_div, m_act;

  int ph_edge, ph_ticks, ph_first, ph_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int div_of(input logic [2:0] c);
    case (c)
      3'b010:  return 8;
      3'b011:  return 64;
      3'b100:  return 256;
      default: return 1024;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_s = 2'b00; m_hist = 0; m_tick = 0; m_div = 0; m_act = 0;
  endtask

  task automatic model_edge(input logic [2:0] c, input logic p, input logic pin);
    int   d, nxt;
    logic cand, dv;
    nxt  = p ? 0 : (m_cnt + 1) % (1 << CntW);
    cand = 1'b0;
    dv   = 1'b0;
    case (c)
      3'b001: cand = !p;
      3'b010, 3'b011, 3'b100, 3'b101: begin
        d    = div_of(c);
        cand = (m_cnt % d == d - 1) && !p;
        dv   = ((nxt / (d / 2)) % 2) == 1;
      end
      3'b110: begin cand = !m_s[1] && m_hist;  dv = m_s[1]; end
      3'b111: begin cand = m_s[1] && !m_hist;  dv = m_s[1]; end
      default: ;
    endcase
    m_tick = cand && !(m_tick && c != 3'b001);
    m_div  = dv;
    m_act  = (c != 3'b000);
    m_hist = m_s[1];
    m_s    = {m_s[0], pin};
    m_cnt  = nxt;
  endtask

  task automatic new_phase();
    ph_edge = 0; ph_ticks = 0; ph_first = -1; ph_last = -1;
  endtask

  task automatic step(input logic [2:0] c, input logic p, input logic pin);
    exp_t e;
    bus.cs = c; bus.psr = p; bus.t0_pin = pin;
    model_edge(c, p, pin);
    e.tick = m_tick; e.div = m_div; e.act = m_act;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("tick", 32'(bus.tick), 32'(e.tick));
    check_eq("div_out", 32'(bus.div_out), 32'(e.div));
    check_eq("active", 32'(bus.active), 32'(e.act));
    ph_edge++;
    if (bus.tick === 1'b1) begin
      ph_ticks++;
      if (ph_first < 0) ph_first = ph_edge;
      ph_last = ph_edge;
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.cs = 3'b010; bus.psr = 1'b0; bus.t0_pin = 1'b0;
    model_reset();
    #22;
    check_eq("rst_tick", 32'(bus.tick), 0);
    check_eq("rst_div", 32'(bus.div_out), 0);
    check_eq("rst_active", 32'(bus.active), 0);
    rst_n = 1'b1;

    // /8 from reset: ticks on edges 8..40.
    new_phase();
    for (int i = 0; i < 40; i++) step(3'b010, 1'b0, 1'b0);
    check_eq("div8_count", ph_ticks, 5);
    check_eq("div8_first", ph_first, 8);
    check_eq("div8_last", ph_last, 40);

    // /1024 with a prescaler clear on edge 500.
    new_phase();
    for (int i = 1; i <= 2560; i++) step(3'b101, (i == 500), 1'b0);
    check_eq("div1024_count", ph_ticks, 2);
    check_eq("div1024_first", ph_first, 1524);
    check_eq("div1024_last", ph_last, 2548);

    // External falling edges, pin period 10.
    new_phase();
    for (int i = 0; i < 60; i++) step(3'b110, 1'b0, logic'((i / 5) % 2));
    check_eq("ext_fall_count", ph_ticks, 5);
    check_eq("ext_fall_first", ph_first, 13);

    new_phase();
    for (int i = 0; i < 60; i++) step(3'b111, 1'b0, logic'((i / 5) % 2));
    check_eq("ext_rise_count", ph_ticks, 6);
    check_eq("ext_rise_first", ph_first, 8);

    // /1 then stop, then back to /8 with the counter still running.
    new_phase();
    for (int i = 0; i < 5; i++) step(3'b001, 1'b0, 1'b0);
    check_eq("div1_count", ph_ticks, 5);
    new_phase();
    for (int i = 0; i < 5; i++) step(3'b000, 1'b0, 1'b0);
    check_eq("stop_count", ph_ticks, 0);
    for (int i = 0; i < 16; i++) step(3'b010, 1'b0, 1'b0);

    // Switch /64 -> /8 at cnt=37.
    step(3'b011, 1'b1, 1'b0);
    for (int i = 0; i < 37; i++) step(3'b011, 1'b0, 1'b0);
    new_phase();
    for (int i = 0; i < 8; i++) step(3'b010, 1'b0, 1'b0);
    check_eq("switch_first", ph_first, 3);

    // Asynchronous reset mid-period.
    step(3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(3'b010, 1'b0, 1'b0);
    check_eq("pre_rst_div", 32'(bus.div_out), 1);
    check_eq("pre_rst_active", 32'(bus.active), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_tick", 32'(bus.tick), 0);
    check_eq("async_rst_div", 32'(bus.div_out), 0);
    check_eq("async_rst_active", 32'(bus.active), 0);
    model_reset();
    #1 rst_n = 1'b1;
    new_phase();
    for (int i = 0; i < 16; i++) step(3'b010, 1'b0, 1'b0);
    check_eq("post_rst_first", ph_first, 8);
    check_eq("post_rst_count", ph_ticks, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer0_prescaler.md
Name: timer0_prescaler

Overview:
Parametrised clock prescaler for the timer0 subsystem. Replaces the fixed divide-by-2^n clock generator with a fully synchronous block: one free-running counter and a one-cycle `tick` clock-enable for the timer0 counter, so no derived clocks exist. Adds stop mode, a prescaler reset, and external-pin clocking on either edge through a synchroniser.

Parameters:
CNT_W, 10, prescaler counter width; must satisfy 2^CNT_W >= every DIVn.
SYNC_STAGES, 2, synchroniser flops on t0_pin; minimum 2.
DIV1, 8, divide ratio for cs=3'b010; power of 2, >= 2.
DIV2, 64, divide ratio for cs=3'b011; power of 2.
DIV3, 256, divide ratio for cs=3'b100; power of 2.
DIV4, 1024, divide ratio for cs=3'b101; power of 2.

Ports:
clk     input   1  system clock; all state on rising edge.
rst_n   input   1  asynchronous active-low reset.
cs      input   3  clock select: 000 stop, 001 /1, 010 /DIV1, 011 /DIV2, 100 /DIV3, 101 /DIV4, 110 t0_pin falling, 111 t0_pin rising.
psr     input   1  synchronous prescaler reset, level-sensitive, active high.
t0_pin  input   1  external clock pin, asynchronous to clk.
tick    output  1  one-cycle count enable to the timer0 counter.
div_out output  1  observable divided square wave, for debug and test.
active  output  1  high when cs != 000.

Behaviour:
- Reset (rst_n=0, asynchronous): cnt=0, all synchroniser and edge flops=0, tick=0, div_out=0, active=0.
- Counter: `cnt` (CNT_W bits) increments by 1 on every clk edge regardless of cs and wraps from 2^CNT_W-1 to 0.
  - psr=1: cnt<=0 on that edge. psr has priority over increment.
  - A cs change does not clear cnt.
- All outputs are registered. Each is a function of pre-edge state and the current cs and psr.
- Internal modes, D = selected DIVn:
  - tick <= (cnt[log2(D)-1:0] == D-1) && !psr.
  - First tick is on the D-th edge after rst_n rises; period is exactly D cycles; high for 1 cycle.
- cs=001: tick <= 1 on every edge except when psr=1. First high after the 1st edge.
- cs=000: tick <= 0; cnt keeps running.
- External modes:
  - t0_pin passes through SYNC_STAGES flops, then one history flop.
  - Falling edge detected as sync=0, hist=1; rising edge as sync=1, hist=0.
  - tick <= detected edge of the selected polarity.
  - Latency is SYNC_STAGES+1 clk edges from the first edge at which the new pin level is sampled.
  - psr does not affect external ticks.
  - The pin must hold each level for at least 2 clk cycles; shorter pulses may be lost, and this is not flagged.
- div_out:
  - Internal divided modes: div_out <= next-cycle cnt bit [log2(D)-1], giving a 50% duty square wave of period D. It rises D/2 edges after a counter clear.
  - cs=001 and cs=000: div_out <= 0.
  - External modes: div_out <= synchronised pin.
- active <= (cs != 3'b000).
- Mode switch mid-count: the new cs is honoured from the next edge. The first period may be short (partial count) but is never shorter than 1 cycle. tick never asserts twice in consecutive cycles, except in mode 001.
- Reset mid-operation: all state clears immediately. No tick is issued on reset release.
- cnt wrap: with D = 2^CNT_W, a tick occurs on the wrap edge only; no extra tick.

Decomposition:
- Package `timer0_pkg`:
  - CS encoding localparams: CS_STOP, CS_DIV1, CS_DIVA..CS_DIVD, CS_EXT_FALL, CS_EXT_RISE.
  - Default divide constants.
  - A clog2 function for divide-mask width.
- Sub-module `t0_sync_edge`:
  - Parameter SYNC_STAGES.
  - Ports clk, rst_n, async_in, sync_out, rise, fall.
  - Reused later for the timer1 external pin.

Test Plan:
- Reset then cs=010, DIV1=8, psr=0 for 40 cycles -> tick high on edges 8,16,24,32,40 only; div_out period 8, 4 high/4 low.
- cs=101 (DIV4=1024), pulse psr for 1 cycle at edge 500 -> no tick at 1024; next tick at edge 500+1024; ticks every 1024 thereafter.
- cs=110, toggle t0_pin with period 10 clk cycles, SYNC_STAGES=2 -> exactly one tick per pin falling edge, 3 edges after sampling; none on rising edges. Then cs=111 -> ticks move to rising edges.
- cs=001 for 5 cycles, then 000 for 5 cycles -> tick=1 on 5 consecutive edges, then 0; active tracks cs; cnt keeps incrementing (checked via div_out after returning to 010).
- Switch cs 011 -> 010 when cnt=37 -> next tick at the edge where cnt low 3 bits = 7 (cnt=39->40), i.e. 3 edges later.
- Assert rst_n=0 asynchronously mid-period -> tick, div_out, active go 0 immediately; after release with cs=010, first tick on the 8th edge.
